// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one serial bus among NUM_MASTERS masters.
// A grant is held until the owner finishes (tx_done), drops its request,
// or the watchdog expires. One turnaround cycle follows every release.
//
// Ports:
//   clk              system clock, rising edge
//   reset            synchronous active-low reset
//   approval_request per-master level request
//   tx_done          per-master end-of-transaction pulse
//   approval_grant   one-hot grant (registered)
//   busy             bus owned or in turnaround (registered)
//   grant_id         index of current/last owner (registered)
//   timeout_err      one-cycle pulse on watchdog release (registered)
module bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         approval_request,
  input  logic [NUM_MASTERS-1:0]         tx_done,
  output logic [NUM_MASTERS-1:0]         approval_grant,
  output logic                           busy,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
  output logic                           timeout_err
);

  localparam int unsigned ID_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic                   busy_nxt;
  logic [ID_W-1:0]        id_nxt;
  logic                   err_nxt;
  logic [CNT_W-1:0]       counter, cnt_nxt;
  logic [ID_W-1:0]        last_owner, last_nxt;

  logic                   found;
  logic [ID_W-1:0]        sel;
  logic [ID_W-1:0]        idx;
  logic                   owner_done;

  // Round-robin pick: scan starting just after the last owner.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      idx = ID_W'((32'(last_owner) + i) % NUM_MASTERS);
      if (!found && approval_request[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Completion and request drop both end the transaction normally.
  assign owner_done = tx_done[grant_id] | ~approval_request[grant_id];

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    grant_nxt = approval_grant;
    busy_nxt  = busy;
    id_nxt    = grant_id;
    err_nxt   = 1'b0;
    cnt_nxt   = counter;
    last_nxt  = last_owner;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        if (found) begin
          grant_nxt = NUM_MASTERS'(1) << sel;
          id_nxt    = sel;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        cnt_nxt = counter + CNT_W'(1);
        // Normal completion wins over a coincident watchdog expiry.
        if (owner_done || (counter == CNT_W'(TIMEOUT - 1))) begin
          err_nxt   = ~owner_done;
          grant_nxt = '0;
          busy_nxt  = 1'b1;
          last_nxt  = grant_id;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      approval_grant <= '0;
      busy           <= 1'b0;
      grant_id       <= '0;
      timeout_err    <= 1'b0;
      counter        <= '0;
      last_owner     <= ID_W'(NUM_MASTERS - 1);
    end else begin
      state          <= state_nxt;
      approval_grant <= grant_nxt;
      busy           <= busy_nxt;
      grant_id       <= id_nxt;
      timeout_err    <= err_nxt;
      counter        <= cnt_nxt;
      last_owner     <= last_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (2 masters, TIMEOUT=16) with an
// expectation queue and a per-cycle invariant monitor.
module tb_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [1:0] done;
  logic [1:0] grant;
  logic       busy;
  logic [0:0] gid;
  logic       terr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [1:0] g;
    logic       b;
    logic       id;
    logic       e;
  } exp_t;

  exp_t sb[$];

  bus_arbiter #(
    .NUM_MASTERS(2),
    .TIMEOUT    (16),
    .CNT_W      (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .approval_request(req),
    .tx_done         (done),
    .approval_grant  (grant),
    .busy            (busy),
    .grant_id        (gid),
    .timeout_err     (terr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_o(input string tag, input logic [1:0] g, input logic b,
                          input logic id, input logic e);
    exp_t x;
    x.tag = tag; x.g = g; x.b = b; x.id = id; x.e = e;
    sb.push_back(x);
  endtask

  task automatic check_o();
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=none expected=entry");
      return;
    end
    x = sb.pop_front();
    assert ((grant === x.g) && (busy === x.b) && (gid[0] === x.id) && (terr === x.e))
    else begin
      errors++;
      $error("FAIL %s observed grant=%b busy=%b id=%b err=%b expected grant=%b busy=%b id=%b err=%b",
             x.tag, grant, busy, gid, terr, x.g, x.b, x.id, x.e);
    end
  endtask

  // Push expectation for the next edge, advance one edge, compare.
  task automatic step(input string tag, input logic [1:0] g, input logic b,
                      input logic id, input logic e);
    expect_o(tag, g, b, id, e);
    tick(1);
    check_o();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 2'b00;
    done  = 2'b00;
    step("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  // Invariants checked every cycle outside reset.
  logic [1:0] prev_grant;
  logic       prev_gid;
  logic       prev_err;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      assert ($onehot0(grant) === 1'b1)
      else begin errors++; $error("FAIL inv_onehot observed=%b expected=onehot0", grant); end
      if (grant != 2'b00) begin
        checks++;
        assert (busy === 1'b1)
        else begin errors++; $error("FAIL inv_busy observed=%b expected=1", busy); end
      end
      if ((grant != 2'b00) && (prev_grant != 2'b00)) begin
        checks++;
        assert (gid[0] === prev_gid)
        else begin errors++; $error("FAIL inv_gid observed=%b expected=%b", gid, prev_gid); end
      end
      if (prev_err === 1'b1) begin
        checks++;
        assert (terr === 1'b0)
        else begin errors++; $error("FAIL inv_err2 observed=%b expected=0", terr); end
      end
    end
    prev_grant = grant;
    prev_gid   = gid[0];
    prev_err   = terr;
  end

  initial begin
    logic [1:0] g;
    logic       own;
    reset = 1'b0;
    req   = 2'b00;
    done  = 2'b00;

    // Reset then single request.
    tick(2);
    step("rst_state", 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step("idle_norq", 2'b00, 1'b0, 1'b0, 1'b0);
    req = 2'b01;
    step("grant0", 2'b01, 1'b1, 1'b0, 1'b0);
    tick(13);
    step("hold0", 2'b01, 1'b1, 1'b0, 1'b0);
    done = 2'b01;
    step("rel0", 2'b00, 1'b1, 1'b0, 1'b0);
    done = 2'b00;
    req  = 2'b00;
    step("turn0", 2'b00, 1'b0, 1'b0, 1'b0);
    step("idle0", 2'b00, 1'b0, 1'b0, 1'b0);

    // Simultaneous requests alternate 01, 10, 01, 10.
    do_reset();
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      own = (k % 2 == 1);
      g   = own ? 2'b10 : 2'b01;
      step("rr_grant", g, 1'b1, own, 1'b0);
      tick(8);
      step("rr_hold", g, 1'b1, own, 1'b0);
      done = g;
      step("rr_rel", 2'b00, 1'b1, own, 1'b0);
      done = 2'b00;
      step("rr_gap", 2'b00, 1'b0, own, 1'b0);
    end

    // Dropping the request releases the bus without a timeout.
    do_reset();
    req = 2'b10;
    step("drop_grant", 2'b10, 1'b1, 1'b1, 1'b0);
    tick(3);
    req = 2'b00;
    step("drop_rel", 2'b00, 1'b1, 1'b1, 1'b0);
    step("drop_turn", 2'b00, 1'b0, 1'b1, 1'b0);

    // Watchdog fires 16 edges after grant; pending master 1 follows.
    do_reset();
    req = 2'b01;
    step("wd_grant", 2'b01, 1'b1, 1'b0, 1'b0);
    req = 2'b11;
    tick(14);
    step("wd_pre", 2'b01, 1'b1, 1'b0, 1'b0);
    step("wd_fire", 2'b00, 1'b1, 1'b0, 1'b1);
    step("wd_turn", 2'b00, 1'b0, 1'b0, 1'b0);
    step("wd_next", 2'b10, 1'b1, 1'b1, 1'b0);
    req = 2'b00;
    step("wd_drop", 2'b00, 1'b1, 1'b1, 1'b0);

    // Foreign tx_done is ignored and the watchdog keeps counting.
    do_reset();
    req = 2'b01;
    step("fd_grant", 2'b01, 1'b1, 1'b0, 1'b0);
    tick(3);
    done = 2'b10;
    step("fd_ignore", 2'b01, 1'b1, 1'b0, 1'b0);
    done = 2'b00;
    tick(10);
    step("fd_pre", 2'b01, 1'b1, 1'b0, 1'b0);
    step("fd_fire", 2'b00, 1'b1, 1'b0, 1'b1);
    req = 2'b00;
    tick(2);

    // Reset during ACTIVE clears everything; master 0 wins afterwards.
    do_reset();
    req = 2'b10;
    step("mr_grant", 2'b10, 1'b1, 1'b1, 1'b0);
    tick(2);
    reset = 1'b0;
    req   = 2'b11;
    step("mr_rst", 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step("mr_first", 2'b01, 1'b1, 1'b0, 1'b0);
    req = 2'b00;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the serial system bus between NUM_MASTERS MasterOut-style masters.
- Each master raises approval_request and waits for busy low and its approval_grant.
- Arbiter grants the bus to exactly one master using round-robin priority.
- Holds the grant until the owner signals tx_done or drops its request, or until a watchdog timeout fires.
- Sits between the master ports and the shared serial lines; drives the master-side busy/approval_grant handshake.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..4).
TIMEOUT, 255, max cycles in ACTIVE before forced release (>=2).
CNT_W, 8, width of watchdog counter; must hold TIMEOUT.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset; sampled on rising clk.
approval_request  input  NUM_MASTERS  per-master bus request, level, held high for the whole transaction.
tx_done  input  NUM_MASTERS  per-master one-cycle pulse marking end of transaction.
approval_grant  output  NUM_MASTERS  one-hot grant, registered.
busy  output  1  bus owned or turning around, registered; broadcast to all masters.
grant_id  output  $clog2(NUM_MASTERS)  index of current or last owner, registered.
timeout_err  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (reset==0 at rising clk), regardless of state or mid-transaction:
  - state=IDLE, approval_grant=0, busy=0, grant_id=0, timeout_err=0, counter=0.
  - RR pointer last_owner=NUM_MASTERS-1, so master 0 has top priority first.
- States: IDLE, ACTIVE, RELEASE.
- IDLE:
  - busy=0, approval_grant=0.
  - If any approval_request bit is 1, select the first requester scanning last_owner+1, last_owner+2, ... modulo NUM_MASTERS.
  - At the same edge: approval_grant=onehot(sel), grant_id=sel, busy=1, counter=0, go ACTIVE.
  - Latency: request sampled at edge N gives grant visible after edge N (1 cycle).
  - With no requests, stay in IDLE.
- ACTIVE:
  - Grant and busy held; counter increments each cycle.
  - Release condition: tx_done[owner]==1, or approval_request[owner]==0. Either or both in the same cycle cause a single release.
  - Else if counter==TIMEOUT-1: timeout_err=1 for the next cycle only, then release.
  - tx_done or request changes from non-owners are ignored; their requests stay pending.
- Release action (edge): approval_grant=0, busy stays 1, last_owner=owner, go RELEASE.
- RELEASE:
  - Single turnaround cycle with busy=1 and no grant.
  - Next edge: busy=0, go IDLE.
  - New grant earliest 2 edges after the release edge, so there is always at least one busy=0 cycle between owners.
- Fairness:
  - After master k completes, master k is lowest priority.
  - Any continuously requesting master is granted within NUM_MASTERS-1 other transactions.
- Invariants:
  - approval_grant is zero or one-hot.
  - approval_grant!=0 implies busy=1.
  - grant_id is stable while the grant is high.
  - timeout_err is never high two consecutive cycles.
- Timeout and tx_done arriving in the same cycle: treated as normal completion, no timeout_err.
- Reset asserted while in ACTIVE: grant drops at that edge; the master sees the grant removed and must abandon its transfer.

Test Plan:
- Reset then single request: reset=0 for 3 cycles, release; approval_request=2'b01 at edge 5 -> approval_grant=2'b01, busy=1, grant_id=0 after edge 5. Pulse tx_done[0] at edge 20 -> grant=0 after edge 20, busy=0 after edge 21.
- Simultaneous requests, round-robin: approval_request=2'b11 held; each owner pulses tx_done after 10 cycles -> grants in the order 01, 10, 01, 10, each separated by RELEASE plus one IDLE cycle with busy=0.
- Request drop as release: master 1 granted, drops approval_request[1] without tx_done -> release on the next edge, no timeout_err.
- Watchdog: TIMEOUT=16, master 0 granted and never completes -> timeout_err=1 exactly one cycle, 16 cycles after the grant edge; grant=0 in the same cycle; a pending master 1 is granted 2 edges later.
- Ignored foreign done: master 0 owns the bus, tx_done[1] pulses -> grant to master 0 unchanged, counter continues.
- Reset mid-operation: master 1 in ACTIVE, reset=0 for one edge -> all outputs 0 after that edge. With both requesting after reset, master 0 is granted first.
